// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer
//   Trace capture buffer for the fetch path. Records (PC, instruction) pairs
//   into a circular buffer while armed. A PC match starts a post-trigger
//   window; after POST_TRIG more captures the buffer freezes for readback.
//
//   Optional feature macro: TRACE_TIMESTAMP_EN
//     When defined, a free-running TS_W-bit cycle counter is stamped into
//     every entry and returned on rd_ts alongside rd_pc.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   cap_valid  capture qualifier for this cycle
//   cap_pc     PC to record
//   cap_instr  instruction to record
//   arm        pulse: clear buffer and start capture (highest priority)
//   trig_en    enable PC-match trigger
//   trig_pc    trigger PC
//   rd_req     read request, honoured in DONE only
//   rd_idx     read index, 0 = oldest entry
//   rd_valid   one-cycle pulse, rd_pc/rd_instr(/rd_ts) valid
//   rd_pc      read PC
//   rd_instr   read instruction
//   rd_ts      read timestamp (TRACE_TIMESTAMP_EN only)
//   state      0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   count      valid entries, saturates at DEPTH
//   wrap       buffer has wrapped since arm
//   trig_idx   readout index of the trigger entry, valid in DONE
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no capture since reset
// ARMED | capturing, waiting for the PC-match trigger
// POST  | capturing the post-trigger window
// DONE  | frozen, buffer available for readback

module pc_trace_buffer #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int TS_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_valid,
    input  logic [ADDR_W-1:0]        cap_pc,
    input  logic [DATA_W-1:0]        cap_instr,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [ADDR_W-1:0]        trig_pc,
    input  logic                     rd_req,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_valid,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [DATA_W-1:0]        rd_instr,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]          rd_ts,
`endif
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrap,
    output logic [$clog2(DEPTH)-1:0] trig_idx
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int POST_LAST_I = (POST_TRIG > 0) ? POST_TRIG - 1 : 0;
    localparam logic [IDX_W-1:0] POST_LAST = IDX_W'(POST_LAST_I);
    localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   CNT_FULL  = (IDX_W+1)'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
            $error("pc_trace_buffer: DEPTH must be a power of 2 and >= 2");
        if (POST_TRIG < 0 || POST_TRIG > DEPTH - 1)
            $error("pc_trace_buffer: POST_TRIG must be in 0..DEPTH-1");
        if (TS_W < 1)
            $error("pc_trace_buffer: TS_W must be >= 1");
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] post_cnt;
    logic [IDX_W-1:0] trig_slot;
    logic [IDX_W-1:0] oldest;
    logic [IDX_W-1:0] rd_slot;

    logic clr;
    logic wr_en;
    logic trig_hit;
    logic trig_match;
    logic rd_hit;

    logic [ADDR_W-1:0] mem_pc    [DEPTH];
    logic [DATA_W-1:0] mem_instr [DEPTH];

    assign trig_match = trig_en && cap_valid && (cap_pc == trig_pc);

    // Next-state and datapath controls. arm overrides everything, including
    // a trigger or write that would otherwise happen in the same cycle.
    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        wr_en    = 1'b0;
        trig_hit = 1'b0;
        if (arm) begin
            state_d = S_ARMED;
            clr     = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ARMED: begin
                    wr_en = cap_valid;
                    if (trig_match) begin
                        trig_hit = 1'b1;
                        state_d  = (POST_TRIG == 0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    wr_en = cap_valid;
                    if (cap_valid && post_cnt == POST_LAST)
                        state_d = S_DONE;
                end
                S_DONE: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    assign state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            count     <= '0;
            wrap      <= 1'b0;
            post_cnt  <= '0;
            trig_slot <= '0;
        end else if (clr) begin
            wr_ptr    <= '0;
            count     <= '0;
            wrap      <= 1'b0;
            post_cnt  <= '0;
            trig_slot <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + IDX_W'(1);
            if (count != CNT_FULL)
                count <= count + (IDX_W+1)'(1);
            if (wr_ptr == PTR_LAST)
                wrap <= 1'b1;
            if (trig_hit)
                trig_slot <= wr_ptr;
            if (state_q == S_POST)
                post_cnt <= post_cnt + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]    <= cap_pc;
            mem_instr[wr_ptr] <= cap_instr;
        end
    end

    // Once wrapped, the slot about to be overwritten holds the oldest entry.
    assign oldest   = wrap ? wr_ptr : '0;
    assign trig_idx = trig_slot - oldest;
    assign rd_slot  = oldest + rd_idx;
    assign rd_hit   = (state_q == S_DONE) && rd_req && ({1'b0, rd_idx} < count);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_pc    <= '0;
            rd_instr <= '0;
        end else begin
            rd_valid <= rd_hit;
            if (rd_hit) begin
                rd_pc    <= mem_pc[rd_slot];
                rd_instr <= mem_instr[rd_slot];
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ts_cnt <= '0;
        else
            ts_cnt <= ts_cnt + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_ts[wr_ptr] <= ts_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_ts <= '0;
        else if (rd_hit)
            rd_ts <= mem_ts[rd_slot];
    end
`endif

endmodule

// File: tb/tb_pc_trace_buffer.sv
// tb_pc_trace_buffer
//   Two instances share one stimulus stream: dut_a (DEPTH=4, POST_TRIG=2)
//   and dut_b (DEPTH=4, POST_TRIG=0). A reference model keeps the full
//   capture history since arm and derives the window, counts and read data
//   from it. Directed steps are followed by a randomized phase.

module tb_pc_trace_buffer;

    localparam int DEPTH = 4;
    localparam int HN    = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cap_valid = 1'b0;
    logic [31:0] cap_pc = '0;
    logic [31:0] cap_instr = '0;
    logic        arm = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        rd_req = 1'b0;
    logic [1:0]  rd_idx = '0;

    logic        rd_valid_a, rd_valid_b;
    logic [31:0] rd_pc_a, rd_pc_b, rd_instr_a, rd_instr_b;
    logic [1:0]  state_a, state_b;
    logic [2:0]  count_a, count_b;
    logic        wrap_a, wrap_b;
    logic [1:0]  trig_idx_a, trig_idx_b;
    logic [15:0] rd_ts_a, rd_ts_b;

    always #5 clk = ~clk;

    pc_trace_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .POST_TRIG(2), .TS_W(16)) dut_a (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid_a), .rd_pc(rd_pc_a), .rd_instr(rd_instr_a),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts(rd_ts_a),
`endif
        .state(state_a), .count(count_a), .wrap(wrap_a), .trig_idx(trig_idx_a)
    );

    pc_trace_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .POST_TRIG(0), .TS_W(16)) dut_b (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid_b), .rd_pc(rd_pc_b), .rd_instr(rd_instr_b),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts(rd_ts_b),
`endif
        .state(state_b), .count(count_b), .wrap(wrap_b), .trig_idx(trig_idx_b)
    );

`ifndef TRACE_TIMESTAMP_EN
    assign rd_ts_a = '0;
    assign rd_ts_b = '0;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: per instance, a history of captures since arm.
    int          m_pt   [2] = '{2, 0};
    int          m_st   [2];
    int          m_n    [2];
    int          m_post [2];
    int          m_tpos [2];
    logic [31:0] h_pc   [2][HN];
    logic [31:0] h_in   [2][HN];
    logic [15:0] h_ts   [2][HN];
    logic        m_rv   [2];
    logic [31:0] m_rpc  [2];
    logic [31:0] m_rin  [2];
    logic [15:0] m_rts  [2];
    logic [15:0] m_ts;

    function automatic int mcount(input int k);
        return (m_n[k] < DEPTH) ? m_n[k] : DEPTH;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_n[k] = 0; m_post[k] = 0; m_tpos[k] = 0;
            m_rv[k] = 1'b0; m_rpc[k] = '0; m_rin[k] = '0; m_rts[k] = '0;
        end
        m_ts = '0;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int cnt;
            int j;
            cnt = mcount(k);
            if (m_st[k] == 3 && rd_req && int'(rd_idx) < cnt) begin
                j = (m_n[k] - cnt + int'(rd_idx)) % HN;
                m_rv[k] = 1'b1;
                m_rpc[k] = h_pc[k][j];
                m_rin[k] = h_in[k][j];
                m_rts[k] = h_ts[k][j];
            end else begin
                m_rv[k] = 1'b0;
            end
            if (arm) begin
                m_st[k] = 1; m_n[k] = 0; m_post[k] = 0;
            end else if ((m_st[k] == 1 || m_st[k] == 2) && cap_valid) begin
                h_pc[k][m_n[k] % HN] = cap_pc;
                h_in[k][m_n[k] % HN] = cap_instr;
                h_ts[k][m_n[k] % HN] = m_ts;
                m_n[k]++;
                if (m_st[k] == 1) begin
                    if (trig_en && cap_pc == trig_pc) begin
                        m_tpos[k] = m_n[k] - 1;
                        m_st[k] = (m_pt[k] == 0) ? 3 : 2;
                    end
                end else begin
                    m_post[k]++;
                    if (m_post[k] == m_pt[k]) m_st[k] = 3;
                end
            end
        end
        m_ts = m_ts + 16'd1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input int k, input logic [1:0] st, input logic [2:0] cnt,
                            input logic wr, input logic rv, input logic [31:0] rp,
                            input logic [31:0] ri, input logic [1:0] ti, input logic [15:0] ts);
        int c;
        c = mcount(k);
        chk($sformatf("state%0d", k), 64'(st), 64'(m_st[k]));
        chk($sformatf("count%0d", k), 64'(cnt), 64'(c));
        chk($sformatf("wrap%0d", k), 64'(wr), 64'(m_n[k] >= DEPTH));
        chk($sformatf("rd_valid%0d", k), 64'(rv), 64'(m_rv[k]));
        chk($sformatf("rd_pc%0d", k), 64'(rp), 64'(m_rpc[k]));
        chk($sformatf("rd_instr%0d", k), 64'(ri), 64'(m_rin[k]));
        if (m_st[k] == 3)
            chk($sformatf("trig_idx%0d", k), 64'(ti), 64'((m_tpos[k] - (m_n[k] - c)) % DEPTH));
`ifdef TRACE_TIMESTAMP_EN
        chk($sformatf("rd_ts%0d", k), 64'(ts), 64'(m_rts[k]));
`else
        if (ts !== 16'h0) chk($sformatf("rd_ts%0d", k), 64'(ts), 64'h0);
`endif
    endtask

    task automatic check_all();
        chk_inst(0, state_a, count_a, wrap_a, rd_valid_a, rd_pc_a, rd_instr_a, trig_idx_a, rd_ts_a);
        chk_inst(1, state_b, count_b, wrap_b, rd_valid_b, rd_pc_b, rd_instr_b, trig_idx_b, rd_ts_b);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cap(input logic [31:0] pc);
        cap_valid = 1'b1;
        cap_pc    = pc;
        cap_instr = $urandom;
        step();
        cap_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic rd(input logic [1:0] idx);
        rd_req = 1'b1;
        rd_idx = idx;
        step();
        rd_req = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_state", 64'(state_a), 64'd0);
        chk("async_count", 64'(count_a), 64'd0);
        chk("async_wrap", 64'(wrap_a), 64'd0);
        chk("async_rd_valid", 64'(rd_valid_a), 64'd0);
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [31:0] exp_pc [4];
    logic [15:0] prev_ts;

    initial begin
        // Power-on reset
        #1;
        model_reset();
        check_all();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 1. reset in the middle of a capture; rd_req in IDLE ignored
        trig_en = 1'b1;
        trig_pc = 32'h100;
        do_arm();
        cap(32'h0);
        cap_valid = 1'b1;
        cap_pc = 32'h4;
        async_reset();
        cap_valid = 1'b0;
        rd(2'd0);
        chk("t1_idle_rd_valid", 64'(rd_valid_a), 64'd0);

        // 2. capture without trigger
        do_arm();
        cap(32'h0); cap(32'h4); cap(32'h8);
        chk("t2_state", 64'(state_a), 64'd1);
        chk("t2_count", 64'(count_a), 64'd3);
        chk("t2_wrap", 64'(wrap_a), 64'd0);

        // 3. trigger with wrap, then readback
        trig_pc = 32'h10;
        do_arm();
        for (int i = 0; i < 7; i++) cap(32'(i * 4));
        chk("t3_state", 64'(state_a), 64'd3);
        chk("t3_count", 64'(count_a), 64'd4);
        chk("t3_wrap", 64'(wrap_a), 64'd1);
        chk("t3_trig_idx", 64'(trig_idx_a), 64'd1);
        exp_pc[0] = 32'h0C; exp_pc[1] = 32'h10; exp_pc[2] = 32'h14; exp_pc[3] = 32'h18;
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1;
            rd_idx = 2'(i);
            step();
            chk("t3_rd_valid", 64'(rd_valid_a), 64'd1);
            chk("t3_rd_pc", 64'(rd_pc_a), 64'(exp_pc[i]));
        end
        rd_req = 1'b0;

        // 4. gaps in cap_valid during POST
        trig_pc = 32'h20;
        do_arm();
        cap(32'h20);
        cap(32'h24);
        step(); step();
        chk("t4_post_state", 64'(state_a), 64'd2);
        cap(32'h28);
        chk("t4_done_state", 64'(state_a), 64'd3);
        chk("t4_count", 64'(count_a), 64'd3);

        // 5. POST_TRIG=0 instance: trigger on first capture
        trig_pc = 32'h40;
        do_arm();
        cap(32'h40);
        chk("t5_state", 64'(state_b), 64'd3);
        chk("t5_count", 64'(count_b), 64'd1);
        chk("t5_trig_idx", 64'(trig_idx_b), 64'd0);
        rd(2'd1);
        chk("t5_rd_oob", 64'(rd_valid_b), 64'd0);
        rd(2'd0);
        chk("t5_rd_pc", 64'(rd_pc_b), 64'h40);

        // 6. arm colliding with a trigger match, then timestamps
        trig_pc = 32'h44;
        do_arm();
        cap(32'h0);
        arm = 1'b1;
        cap(32'h44);
        arm = 1'b0;
        chk("t6_state", 64'(state_a), 64'd1);
        chk("t6_count", 64'(count_a), 64'd0);
        trig_pc = 32'h200;
        cap(32'h200); cap(32'h204); cap(32'h208);
        chk("t6_done", 64'(state_a), 64'd3);
        rd(2'd0);
        prev_ts = rd_ts_a;
        for (int i = 1; i < 3; i++) begin
            rd(2'(i));
            chk("t6_rd_pc", 64'(rd_pc_a), 64'(32'h200 + 32'(i * 4)));
`ifdef TRACE_TIMESTAMP_EN
            chk("t6_ts_step", 64'(rd_ts_a - prev_ts), 64'd1);
            prev_ts = rd_ts_a;
`endif
        end

        // Randomized phase
        do_arm();
        for (int i = 0; i < 400; i++) begin
            arm       = ($urandom_range(0, 29) == 0);
            cap_valid = ($urandom_range(0, 3) != 0);
            cap_pc    = 32'($urandom_range(0, 7) * 4);
            cap_instr = $urandom;
            trig_en   = ($urandom_range(0, 3) != 0);
            if (arm) trig_pc = 32'($urandom_range(0, 7) * 4);
            rd_req    = $urandom_range(0, 1) == 1;
            rd_idx    = 2'($urandom_range(0, 3));
            step();
        end
        arm = 1'b0; cap_valid = 1'b0; rd_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
